// File: rtl/sample_feeder.sv
// Buffers labelled training samples written by the host and replays them,
// epoch after epoch, over a valid/ready handshake to the neuron controller.
module sample_feeder #(
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int EPOCH_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               wrEn,
  input  logic [6:0]         x1Wr,
  input  logic [6:0]         x2Wr,
  input  logic [1:0]         tWr,
  input  logic               start,
  input  logic               stop,
  input  logic [EPOCH_W-1:0] maxEpoch,
  output logic               sampleValid,
  input  logic               sampleReady,
  output logic [6:0]         x1Out,
  output logic [6:0]         x2Out,
  output logic [1:0]         tOut,
  output logic               lastSample,
  output logic [AW:0]        nOut,
  output logic [EPOCH_W-1:0] epochCount,
  output logic               full,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [AW:0]        N_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]        N_ONE     = (AW+1)'(1);
  localparam logic [AW-1:0]      P_ONE     = AW'(1);
  localparam logic [EPOCH_W-1:0] E_ONE     = EPOCH_W'(1);
  localparam logic [EPOCH_W-1:0] EPOCH_MAX = '1;

  logic [15:0]        mem_q [DEPTH];

  state_t             state_q, state_d;
  logic [AW:0]        n_q, n_d;
  logic [AW-1:0]      ptr_q, ptr_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               valid_q, valid_d;
  logic [6:0]         x1_q, x1_d;
  logic [6:0]         x2_q, x2_d;
  logic [1:0]         t_q, t_d;
  logic               last_q, last_d;

  logic               mem_we;
  logic               load;
  logic               transfer;
  logic               at_last;
  logic [AW-1:0]      rd_idx;
  logic [15:0]        rd_data;
  logic [15:0]        wr_data;
  logic [AW:0]        last_idx;
  logic [EPOCH_W-1:0] epoch_inc;

  assign wr_data = {x1Wr, x2Wr, tWr};

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    ptr_d     = ptr_q;
    epoch_d   = epoch_q;
    valid_d   = valid_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    t_d       = t_q;
    last_d    = last_q;
    mem_we    = 1'b0;
    load      = 1'b0;
    rd_idx    = ptr_q;
    rd_data   = '0;
    last_idx  = n_q - N_ONE;
    transfer  = valid_q && sampleReady;
    at_last   = ({1'b0, ptr_q} == last_idx);
    epoch_inc = (epoch_q == EPOCH_MAX) ? epoch_q : epoch_q + E_ONE;

    unique case (state_q)
      IDLE: begin
        if (wrEn && !full) begin
          mem_we = 1'b1;
          n_d    = n_q + N_ONE;
        end
        // start sees the sample count including a same-cycle write
        last_idx = n_d - N_ONE;
        if (start && (n_d != '0)) begin
          state_d = STREAM;
          ptr_d   = '0;
          epoch_d = '0;
          valid_d = 1'b1;
          load    = 1'b1;
          rd_idx  = '0;
        end
      end
      STREAM: begin
        if (transfer) begin
          if (at_last) begin
            epoch_d = epoch_inc;
            if ((maxEpoch != '0) && (epoch_inc == maxEpoch)) begin
              state_d = DONE;
              valid_d = 1'b0;
            end else begin
              ptr_d = '0;
            end
          end else begin
            ptr_d = ptr_q + P_ONE;
          end
          load   = 1'b1;
          rd_idx = ptr_d;
        end
        if (stop) begin
          state_d = DONE;
          valid_d = 1'b0;
        end
      end
      DONE: begin
        if (start && (n_q != '0)) begin
          state_d = STREAM;
          ptr_d   = '0;
          epoch_d = '0;
          valid_d = 1'b1;
          load    = 1'b1;
          rd_idx  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bypass covers a write and start to an empty buffer in one cycle
    if (load) begin
      rd_data = (mem_we && (rd_idx == n_q[AW-1:0])) ? wr_data : mem_q[rd_idx];
      x1_d    = rd_data[15:9];
      x2_d    = rd_data[8:2];
      t_d     = rd_data[1:0];
      last_d  = ({1'b0, rd_idx} == last_idx);
    end

    if (clear) begin
      state_d = IDLE;
      n_d     = '0;
      ptr_d   = '0;
      epoch_d = '0;
      valid_d = 1'b0;
      x1_d    = '0;
      x2_d    = '0;
      t_d     = '0;
      last_d  = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[n_q[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      ptr_q   <= '0;
      epoch_q <= '0;
      valid_q <= 1'b0;
      x1_q    <= '0;
      x2_q    <= '0;
      t_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      ptr_q   <= ptr_d;
      epoch_q <= epoch_d;
      valid_q <= valid_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      t_q     <= t_d;
      last_q  <= last_d;
    end
  end

  assign sampleValid = valid_q;
  assign x1Out       = x1_q;
  assign x2Out       = x2_q;
  assign tOut        = t_q;
  assign lastSample  = last_q;
  assign nOut        = n_q;
  assign epochCount  = epoch_q;
  assign full        = (n_q == N_FULL);
  assign busy        = (state_q == STREAM);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_sample_feeder.sv
// Directed self-checking bench for sample_feeder with hand-computed expectations.
module tb_sample_feeder;

  localparam int DEPTH   = 64;
  localparam int AW      = 6;
  localparam int EPOCH_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               wrEn;
  logic [6:0]         x1Wr;
  logic [6:0]         x2Wr;
  logic [1:0]         tWr;
  logic               start;
  logic               stop;
  logic [EPOCH_W-1:0] maxEpoch;
  logic               sampleValid;
  logic               sampleReady;
  logic [6:0]         x1Out;
  logic [6:0]         x2Out;
  logic [1:0]         tOut;
  logic               lastSample;
  logic [AW:0]        nOut;
  logic [EPOCH_W-1:0] epochCount;
  logic               full;
  logic               busy;
  logic               done;

  int checks   = 0;
  int failures = 0;

  sample_feeder #(.DEPTH(DEPTH), .AW(AW), .EPOCH_W(EPOCH_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .wrEn(wrEn),
    .x1Wr(x1Wr), .x2Wr(x2Wr), .tWr(tWr),
    .start(start), .stop(stop), .maxEpoch(maxEpoch),
    .sampleValid(sampleValid), .sampleReady(sampleReady),
    .x1Out(x1Out), .x2Out(x2Out), .tOut(tOut), .lastSample(lastSample),
    .nOut(nOut), .epochCount(epochCount), .full(full), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // start/stop last one edge; sampleReady holds its value afterwards
  task automatic applyStimulus(input logic st, input logic sp, input logic rdy);
    start       = st;
    stop        = sp;
    sampleReady = rdy;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic writeSample(input int a, input int b, input int t, input logic st);
    wrEn  = 1'b1;
    x1Wr  = 7'(a);
    x2Wr  = 7'(b);
    tWr   = 2'(t);
    start = st;
    @(posedge clk);
    #1;
    wrEn  = 1'b0;
    start = 1'b0;
  endtask

  task automatic checkSample(input string tag, input int a, input int b, input int t, input int last);
    checkOutput({tag, "_valid"}, sampleValid, 1);
    checkOutput({tag, "_x1"}, $signed(x1Out), a);
    checkOutput({tag, "_x2"}, $signed(x2Out), b);
    checkOutput({tag, "_t"}, $signed(tOut), t);
    checkOutput({tag, "_last"}, lastSample, last);
  endtask

  int expX1 [3] = '{5, -7, 10};
  int expX2 [3] = '{-3, 2, 10};
  int expT  [3] = '{1, -1, 1};

  initial begin
    rst = 1'b1; clear = 1'b0; wrEn = 1'b0; x1Wr = '0; x2Wr = '0; tWr = '0;
    start = 1'b0; stop = 1'b0; maxEpoch = '0; sampleReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("rst_n", nOut, 0);
    checkOutput("rst_valid", sampleValid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_epoch", epochCount, 0);

    // Three samples, two epochs, ready held high
    writeSample(5, -3, 1, 1'b0);
    writeSample(-7, 2, -1, 1'b0);
    writeSample(10, 10, 1, 1'b0);
    checkOutput("load_n", nOut, 3);
    maxEpoch = 16'd2;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checkSample($sformatf("ep_s%0d", i), expX1[i % 3], expX2[i % 3], expT[i % 3], (i % 3 == 2) ? 1 : 0);
      checkOutput($sformatf("ep_epoch%0d", i), epochCount, i / 3);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("lim_done", done, 1);
    checkOutput("lim_valid", sampleValid, 0);
    checkOutput("lim_epoch", epochCount, 2);
    checkOutput("lim_busy", busy, 0);

    // Stall: ready 1,0,0,1
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkSample("st_s0", 5, -3, 1, 0);
    checkOutput("st_epoch", epochCount, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkSample("st_s1a", -7, 2, -1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkSample("st_s1b", -7, 2, -1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkSample("st_s1c", -7, 2, -1, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkSample("st_s2", 10, 10, 1, 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("st_stop_done", done, 1);
    checkOutput("st_stop_valid", sampleValid, 0);
    checkOutput("st_stop_epoch", epochCount, 1);

    // Unlimited mode, stop on 2nd sample of epoch 4
    maxEpoch = 16'd0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);
    checkSample("ul_s10", -7, 2, -1, 0);
    checkOutput("ul_epoch_pre", epochCount, 3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("ul_done", done, 1);
    checkOutput("ul_valid", sampleValid, 0);
    checkOutput("ul_epoch", epochCount, 3);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkSample("ul_restart", 5, -3, 1, 0);
    checkOutput("ul_restart_epoch", epochCount, 0);
    checkOutput("ul_restart_busy", busy, 1);

    // clear mid-stream
    clear = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    clear = 1'b0;
    checkOutput("clr_n", nOut, 0);
    checkOutput("clr_valid", sampleValid, 0);
    checkOutput("clr_epoch", epochCount, 0);
    checkOutput("clr_busy", busy, 0);

    // start on empty buffer is ignored
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("empty_busy", busy, 0);
    checkOutput("empty_valid", sampleValid, 0);

    // write and start together on empty buffer
    writeSample(3, -2, -1, 1'b1);
    checkOutput("ws_n", nOut, 1);
    checkOutput("ws_busy", busy, 1);
    checkSample("ws_s0", 3, -2, -1, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkSample("ws_s0b", 3, -2, -1, 1);
    checkOutput("ws_epoch1", epochCount, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("ws_epoch2", epochCount, 2);

    // rst mid-stream
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    checkOutput("rs_n", nOut, 0);
    checkOutput("rs_valid", sampleValid, 0);
    checkOutput("rs_epoch", epochCount, 0);
    checkOutput("rs_busy", busy, 0);

    // Overfill: DEPTH+2 writes, only the first DEPTH kept
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH) writeSample(i, -i, (i % 2 == 0) ? 1 : -1, 1'b0);
      else           writeSample(-1, -1, -1, 1'b0);
    end
    checkOutput("full_n", nOut, DEPTH);
    checkOutput("full_flag", full, 1);
    maxEpoch = 16'd1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("fr_x1_%0d", i), $signed(x1Out), i);
      checkOutput($sformatf("fr_x2_%0d", i), $signed(x2Out), -i);
      if (i == DEPTH - 1) checkOutput("fr_last", lastSample, 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("fr_done", done, 1);
    checkOutput("fr_valid", sampleValid, 0);
    checkOutput("fr_epoch", epochCount, 1);
    checkOutput("fr_n", nOut, DEPTH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
